// File: rtl/interrupt_controller.sv
// Interrupt controller: synchronises and latches IRQs, owns IE, raises a single-level vectored request, and wakes the core from HALT.
// Latency: IRQ pin to PENDING takes SYNC_STAGES+1 edges; a COMMIT raises INT_REQ one cycle later. INT_REQ is held until INT_ACK or a committed DI.
module interrupt_controller #(
  parameter int          NUM_IRQ       = 4,
  parameter logic [15:0] VECTOR_BASE   = 16'h0010,
  parameter logic [15:0] VECTOR_STRIDE = 16'h0004,
  parameter int          SYNC_STAGES   = 2
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               COMMIT,
  input  logic               EIX,
  input  logic               DIX,
  input  logic               RETIX,
  input  logic               PC_ENX,
  input  logic [NUM_IRQ-1:0] IRQ,
  input  logic               INT_ACK,
  output logic               INT_REQ,
  output logic [15:0]        INT_VECTOR,
  output logic [2:0]         INT_ID,
  output logic               IE,
  output logic               IN_SERVICE,
  output logic [NUM_IRQ-1:0] PENDING,
  output logic               WAKE
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

  state_t             state;
  logic               ie_saved;
  logic               ack_take;
  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] sync_prev;
  logic [NUM_IRQ-1:0] irq_rise;
  logic [NUM_IRQ-1:0] pend_clr;
  logic [NUM_IRQ-1:0] pend_nxt;
  logic [2:0]         sel_id;
  logic [15:0]        sel_vector;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      sync_prev <= '0;
    end else begin
      sync_q[0] <= IRQ;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      sync_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign irq_rise = sync_q[SYNC_STAGES-1] & ~sync_prev;
  assign ack_take = (state == S_REQ) && INT_ACK;

  // Lowest pending index wins; the clear mask targets the frozen INT_ID, not the live selection.
  always_comb begin
    sel_id   = '0;
    pend_clr = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (PENDING[i]) sel_id = 3'(i);
    end
    for (int i = 0; i < NUM_IRQ; i++) begin
      pend_clr[i] = ack_take && (INT_ID == 3'(i));
    end
  end

  assign sel_vector = VECTOR_BASE + VECTOR_STRIDE * {13'd0, sel_id};
  assign pend_nxt   = (PENDING & ~pend_clr) | irq_rise;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= S_IDLE;
      INT_REQ    <= 1'b0;
      INT_VECTOR <= '0;
      INT_ID     <= '0;
      IE         <= 1'b0;
      ie_saved   <= 1'b0;
      IN_SERVICE <= 1'b0;
      PENDING    <= '0;
      WAKE       <= 1'b0;
    end else begin
      PENDING <= pend_nxt;
      WAKE    <= !PC_ENX && (PENDING == '0) && (pend_nxt != '0);
      if (COMMIT && DIX)      IE <= 1'b0;
      else if (COMMIT && EIX) IE <= 1'b1;
      case (state)
        S_IDLE: begin
          if (COMMIT && IE && (PENDING != '0)) begin
            state      <= S_REQ;
            INT_REQ    <= 1'b1;
            INT_ID     <= sel_id;
            INT_VECTOR <= sel_vector;
          end
        end
        S_REQ: begin
          if (INT_ACK) begin
            state      <= S_SERVICE;
            INT_REQ    <= 1'b0;
            IN_SERVICE <= 1'b1;
            ie_saved   <= IE;
            IE         <= 1'b0;
          end else if (COMMIT && DIX) begin
            state      <= S_IDLE;
            INT_REQ    <= 1'b0;
            INT_ID     <= '0;
            INT_VECTOR <= '0;
          end
        end
        S_SERVICE: begin
          if (COMMIT && RETIX) begin
            state      <= S_IDLE;
            IN_SERVICE <= 1'b0;
            IE         <= ie_saved;
            INT_ID     <= '0;
            INT_VECTOR <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios then random strobes, checked against a behavioural model.
module tb_interrupt_controller;
  localparam int N = 4;
  localparam int S = 2;

  logic         CLK = 1'b0;
  logic         RESET_N, COMMIT, EIX, DIX, RETIX, PC_ENX, INT_ACK;
  logic [N-1:0] IRQ;
  logic         a_req, a_ie, a_svc, a_wake, b_req, b_ie, b_svc, b_wake;
  logic [15:0]  a_vec, b_vec;
  logic [2:0]   a_id, b_id;
  logic [N-1:0] a_pend, b_pend;

  int checks = 0;
  int errors = 0;

  // Model state: 0 idle, 1 request presented, 2 in service
  int           m_state, m_id;
  bit [N-1:0]   m_pend;
  bit           m_ie, m_saved, m_wake;
  bit [N-1:0]   hist [S+1];

  interrupt_controller #(.NUM_IRQ(N), .VECTOR_BASE(16'h0010), .VECTOR_STRIDE(16'h0004), .SYNC_STAGES(S)) dut_a (
    .CLK(CLK), .RESET_N(RESET_N), .COMMIT(COMMIT), .EIX(EIX), .DIX(DIX), .RETIX(RETIX),
    .PC_ENX(PC_ENX), .IRQ(IRQ), .INT_ACK(INT_ACK), .INT_REQ(a_req), .INT_VECTOR(a_vec),
    .INT_ID(a_id), .IE(a_ie), .IN_SERVICE(a_svc), .PENDING(a_pend), .WAKE(a_wake));

  interrupt_controller #(.NUM_IRQ(N), .VECTOR_BASE(16'hFFF8), .VECTOR_STRIDE(16'h0004), .SYNC_STAGES(S)) dut_b (
    .CLK(CLK), .RESET_N(RESET_N), .COMMIT(COMMIT), .EIX(EIX), .DIX(DIX), .RETIX(RETIX),
    .PC_ENX(PC_ENX), .IRQ(IRQ), .INT_ACK(INT_ACK), .INT_REQ(b_req), .INT_VECTOR(b_vec),
    .INT_ID(b_id), .IE(b_ie), .IN_SERVICE(b_svc), .PENDING(b_pend), .WAKE(b_wake));

  always #5 CLK = ~CLK;

  function automatic void m_reset();
    m_state = 0; m_id = 0; m_pend = '0; m_ie = 0; m_saved = 0; m_wake = 0;
    for (int k = 0; k <= S; k++) hist[k] = '0;
  endfunction

  function automatic void m_step();
    bit [N-1:0] rise, nxt;
    bit         ie_n, found;
    rise = hist[S-1] & ~hist[S];
    for (int k = S; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = IRQ;
    nxt  = m_pend;
    ie_n = m_ie;
    if (COMMIT && DIX)      ie_n = 0;
    else if (COMMIT && EIX) ie_n = 1;
    if (m_state == 0) begin
      if (COMMIT && m_ie && m_pend != 0) begin
        m_state = 1;
        found = 0;
        for (int i = 0; i < N; i++) if (!found && m_pend[i]) begin m_id = i; found = 1; end
      end
    end else if (m_state == 1) begin
      if (INT_ACK) begin
        nxt[m_id] = 0; m_saved = m_ie; ie_n = 0; m_state = 2;
      end else if (COMMIT && DIX) begin
        m_state = 0; m_id = 0;
      end
    end else begin
      if (COMMIT && RETIX) begin
        ie_n = m_saved; m_state = 0; m_id = 0;
      end
    end
    nxt    = nxt | rise;
    m_wake = !PC_ENX && m_pend == 0 && nxt != 0;
    m_pend = nxt;
    m_ie   = ie_n;
  endfunction

  function automatic logic [15:0] m_vec(input int base);
    int t;
    t = base + m_id * 4;
    return (m_state == 0) ? 16'h0000 : t[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".req"},   32'(a_req),  32'(m_state == 1));
    chk({tag, ".svc"},   32'(a_svc),  32'(m_state == 2));
    chk({tag, ".id"},    32'(a_id),   32'(m_id));
    chk({tag, ".vec"},   32'(a_vec),  32'(m_vec('h0010)));
    chk({tag, ".vecb"},  32'(b_vec),  32'(m_vec('hFFF8)));
    chk({tag, ".ie"},    32'(a_ie),   32'(m_ie));
    chk({tag, ".pend"},  32'(a_pend), 32'(m_pend));
    chk({tag, ".wake"},  32'(a_wake), 32'(m_wake));
    chk({tag, ".reqb"},  32'(b_req),  32'(m_state == 1));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".z_req"},  32'(a_req),  32'd0);
    chk({tag, ".z_vec"},  32'(a_vec),  32'd0);
    chk({tag, ".z_id"},   32'(a_id),   32'd0);
    chk({tag, ".z_ie"},   32'(a_ie),   32'd0);
    chk({tag, ".z_svc"},  32'(a_svc),  32'd0);
    chk({tag, ".z_pend"}, 32'(a_pend), 32'd0);
    chk({tag, ".z_wake"}, 32'(a_wake), 32'd0);
  endtask

  // Inputs change only after the falling edge; the model advances on each rising edge
  task automatic tick(input string tag);
    @(posedge CLK);
    if (RESET_N) m_step(); else m_reset();
    @(negedge CLK);
    check_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) tick(tag);
  endtask

  task automatic commit(input bit e, input bit d, input bit r, input string tag);
    COMMIT = 1; EIX = e; DIX = d; RETIX = r;
    tick(tag);
    COMMIT = 0; EIX = 0; DIX = 0; RETIX = 0;
  endtask

  task automatic ack(input string tag);
    INT_ACK = 1;
    tick(tag);
    INT_ACK = 0;
  endtask

  initial begin
    RESET_N = 0; COMMIT = 0; EIX = 0; DIX = 0; RETIX = 0; PC_ENX = 1; INT_ACK = 0; IRQ = '0;
    m_reset();
    idle(2, "por");
    check_zero("por");
    RESET_N = 1;
    tick("rel");

    // Basic entry on IRQ[2]
    commit(1, 0, 0, "ei");
    chk("ie_set", 32'(a_ie), 32'd1);
    IRQ = 4'b0100;
    idle(2, "sync2");
    chk("pend_not_yet", 32'(a_pend), 32'd0);
    tick("sync3");
    chk("pend_3edges", 32'(a_pend), 32'b0100);
    commit(0, 0, 0, "enter2");
    chk("req2", 32'(a_req), 32'd1);
    chk("id2", 32'(a_id), 32'd2);
    chk("vec2", 32'(a_vec), 32'h0018);
    ack("ack2");
    chk("ack2_pend", 32'(a_pend), 32'd0);
    chk("ack2_ie", 32'(a_ie), 32'd0);
    chk("ack2_svc", 32'(a_svc), 32'd1);
    commit(0, 0, 1, "reti2");
    IRQ = '0;
    idle(3, "drain");

    // Priority: IRQ[3] and IRQ[1] together
    IRQ = 4'b1010;
    idle(3, "pri_sync");
    commit(0, 0, 0, "pri_enter");
    chk("pri_id", 32'(a_id), 32'd1);
    chk("pri_vec", 32'(a_vec), 32'h0014);
    ack("pri_ack");
    commit(0, 0, 1, "pri_reti");
    chk("pri_ie_restored", 32'(a_ie), 32'd1);
    commit(0, 0, 0, "pri_enter3");
    chk("pri_id3", 32'(a_id), 32'd3);
    chk("pri_vec3", 32'(a_vec), 32'h001C);
    ack("pri_ack3");
    commit(0, 0, 1, "pri_reti3");
    IRQ = '0;
    idle(3, "drain");

    // Masking and withdraw
    commit(0, 1, 0, "di");
    IRQ = 4'b0001;
    idle(3, "mask_sync");
    commit(0, 0, 0, "masked");
    chk("masked_req", 32'(a_req), 32'd0);
    chk("masked_pend", 32'(a_pend), 32'd1);
    commit(1, 0, 0, "unmask");
    commit(0, 0, 0, "unmask_enter");
    chk("unmask_req", 32'(a_req), 32'd1);
    commit(0, 1, 0, "withdraw");
    chk("wd_req", 32'(a_req), 32'd0);
    chk("wd_pend", 32'(a_pend), 32'd1);
    commit(0, 0, 1, "reti_idle");
    chk("reti_idle_svc", 32'(a_svc), 32'd0);
    chk("reti_idle_pend", 32'(a_pend), 32'd1);

    // Collisions
    commit(1, 0, 0, "ei_c");
    commit(1, 1, 0, "eidi");
    chk("eidi_ie", 32'(a_ie), 32'd0);
    commit(1, 0, 0, "ei_c2");
    commit(0, 0, 0, "enter0");
    IRQ = '0;
    idle(3, "fall0");
    IRQ = 4'b0001;
    idle(2, "rise0");
    ack("ack_reedge");
    chk("reedge_pend0", 32'(a_pend[0]), 32'd1);
    chk("reedge_svc", 32'(a_svc), 32'd1);
    commit(0, 0, 1, "reti_c");
    commit(0, 0, 0, "enter0b");
    ack("ack0b");
    commit(0, 1, 0, "di_in_svc");
    commit(0, 0, 1, "reti_c2");
    commit(0, 1, 0, "di_c");
    IRQ = '0;
    idle(3, "drain");

    // Halt wake
    PC_ENX = 0;
    IRQ = 4'b0010;
    idle(3, "wake_sync");
    chk("wake_hi", 32'(a_wake), 32'd1);
    tick("wake_lo");
    chk("wake_pulse", 32'(a_wake), 32'd0);
    chk("wake_noreq", 32'(a_req), 32'd0);
    PC_ENX = 1;

    // Vector wrap on the high-base instance
    commit(1, 0, 0, "ei_w");
    commit(0, 0, 0, "enter1");
    ack("ack1");
    IRQ = 4'b1010;
    idle(3, "wrap_sync");
    commit(0, 0, 1, "reti_w");
    commit(0, 0, 0, "enter3w");
    chk("wrap_vec", 32'(b_vec), 32'h0004);
    chk("wrap_id", 32'(b_id), 32'd3);

    // Asynchronous reset while a request is presented
    RESET_N = 0;
    #1;
    m_reset();
    check_zero("arst");
    tick("arst_hold");
    check_zero("arst_hold");
    IRQ = '0;
    RESET_N = 1;
    tick("arst_rel");
    check_zero("arst_rel");

    // Random strobes against the model
    for (int k = 0; k < 1500; k++) begin
      COMMIT  = ($urandom_range(0, 1) == 1);
      EIX     = ($urandom_range(0, 3) == 0);
      DIX     = ($urandom_range(0, 6) == 0);
      RETIX   = ($urandom_range(0, 4) == 0);
      INT_ACK = ($urandom_range(0, 4) == 0);
      PC_ENX  = ($urandom_range(0, 4) != 0);
      for (int b = 0; b < N; b++) if ($urandom_range(0, 19) == 0) IRQ[b] = ~IRQ[b];
      tick("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
